// File: rtl/sar_search.sv
// sar_search: successive-approximation searcher. It recovers an unknown
// WIDTH-bit value A by presenting trial operands B to an external
// combinational magnitude comparator and reading back its flags.
// The search runs MSB first, one trial per clock.
//
// Optional feature macro: EARLY_EXIT_EN. When it is defined, an equal flag
// (C2) ends the search on that trial. When it is undefined, every search
// takes exactly WIDTH trials.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   start      request a new search; sampled only in IDLE
//   C2/C1/C0   comparator flags A==B / A>B / A<B (valid in the same cycle as B)
//   B          registered trial operand to the comparator
//   result     recovered A; valid while done=1 and held afterwards
//   busy       high while trials are running
//   done       one-cycle completion pulse
//   err        flag protocol violation in the last search; cleared by an
//              accepted start
//   state_dbg  current FSM state (IDLE=0, TRIAL=1, DONE=2)
//
// Handshake: start is a request that is accepted only in IDLE. busy rises
// on the next cycle and stays high through the trial cycles. done pulses
// for one cycle with busy low. Any start seen while busy or done is high
// is dropped and is not queued.
module sar_search #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             C2,
    input  logic             C1,
    input  logic             C0,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       state_dbg
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] TRIAL = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam int KW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [KW-1:0]    K_TOP = KW'(WIDTH - 1);

    logic [1:0]       state;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] mask_k;
    logic [WIDTH-1:0] mask_next;
    logic [WIDTH-1:0] trial_kept;
    logic             flags_ok;

    // Decode the registered state. busy and done therefore never glitch
    // combinationally on the inputs.
    assign busy      = (state == TRIAL);
    assign done      = (state == DONE);
    assign state_dbg = state;

    always_comb begin
        mask_k     = ONE << k;
        // When k is 0 this wraps. The value is unused then, because the
        // search finishes on that trial.
        mask_next  = ONE << (k - 1'b1);
        flags_ok   = ({C2, C1, C0} == 3'b100) ||
                     ({C2, C1, C0} == 3'b010) ||
                     ({C2, C1, C0} == 3'b001);
        // A < B means the bit under test overshot, so drop it. Otherwise keep it.
        trial_kept = C0 ? (B & ~mask_k) : B;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            k      <= '0;
            B      <= '0;
            result <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= TRIAL;
                        B     <= MSB;
                        k     <= K_TOP;
                        err   <= 1'b0;
                    end
                end
                TRIAL: begin
                    if (!flags_ok) begin
                        err    <= 1'b1;
                        result <= '0;
                        state  <= DONE;
`ifdef EARLY_EXIT_EN
                    end else if (C2) begin
                        result <= B;
                        state  <= DONE;
`endif
                    end else if (k == '0) begin
                        result <= trial_kept;
                        state  <= DONE;
                    end else begin
                        B <= trial_kept | mask_next;
                        k <= k - 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    B     <= '0;
                end
                default: begin
                    state <= IDLE;
                    B     <= '0;
                end
            endcase
        end
    end

endmodule
